// File: rtl/pagerank_pkg.sv
// pagerank_pkg: shared types and fixed-point constants for the PageRank tile.
//   pr_state_e       : controller states (IDLE..DONE)
//   pr_d_fix(w)      : round(0.15 * 2^w), the damping complement
//   pr_db(w)         : 2^w - D_FIX, scales every link contribution
//   pr_dn(w, n)      : D_FIX / n, the per-page teleport term
//   pr_init_v(w, n)  : 2^w / n, uniform starting value
// The functions are evaluated at elaboration to build localparams in the top.
package pagerank_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SCAN,
    REQ,
    WAIT,
    ACC,
    COMMIT,
    DONE
  } pr_state_e;

  // Integer rounding of 0.15 * 2^w: (15 * 2^w + 50) / 100.
  function automatic logic [63:0] pr_d_fix(input int width);
    return ((64'd15 << width) + 64'd50) / 64'd100;
  endfunction

  function automatic logic [63:0] pr_db(input int width);
    return (64'd1 << width) - pr_d_fix(width);
  endfunction

  function automatic logic [63:0] pr_dn(input int width, input int n_total);
    return pr_d_fix(width) / 64'(n_total);
  endfunction

  function automatic logic [63:0] pr_init_v(input int width, input int n_total);
    return (64'd1 << width) / 64'(n_total);
  endfunction

endpackage

// File: rtl/pr_contrib.sv
// pr_contrib: combinational link contribution, c = (DB * w * v) >> (2*WIDTH).
//   w : out-link weight (1/outdegree), fixed point scaled by 2^WIDTH
//   v : committed page value
//   c : contribution, truncated to WIDTH bits
// The product is carried at full 3*WIDTH precision before the shift.
module pr_contrib #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] DB   = '0
) (
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] c
);

  logic [3*WIDTH-1:0] prod;

  assign prod = {{(2*WIDTH){1'b0}}, DB} *
                {{(2*WIDTH){1'b0}}, w} *
                {{(2*WIDTH){1'b0}}, v};
  assign c    = prod[3*WIDTH-1:2*WIDTH];

endmodule

// File: rtl/pagerank_tile.sv
// pagerank_tile: iterative fixed-point PageRank engine for one NoC tile.
// Owns pages tile_id*N_LOCAL .. tile_id*N_LOCAL+N_LOCAL-1 of N_TOTAL.
// Ports:
//   clk, reset (async, active-high)
//   tile_id              : which slice of the global pages is local
//   adjacency            : bit [r*N_TOTAL+c] = global page c links to local row r
//   weights              : per local page out-link weight (1/outdegree)
//   start                : pulse, begins a run from IDLE
//   req_valid/ready/page : remote contribution request (page held until ready)
//   rsp_valid/page/data  : remote contribution response
//   qry_valid/page       : contribution query from the NoC
//   rpl_valid/data       : registered reply, one cycle after the query
//   busy, done (sticky), iter_count, vals (committed values)
// Build option: PR_CONVERGE_EN adds max-delta convergence detection;
// without it the run always lasts MAX_ITER iterations.
module pagerank_tile
  import pagerank_pkg::*;
#(
  parameter  int N_LOCAL  = 16,
  parameter  int N_TOTAL  = 64,
  parameter  int WIDTH    = 16,
  parameter  int MAX_ITER = 32,
  parameter  int EPS      = 4,
  localparam int PW       = $clog2(N_TOTAL),
  localparam int TW       = $clog2(N_TOTAL / N_LOCAL),
  localparam int IW       = $clog2(MAX_ITER) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [TW-1:0]              tile_id,
  input  logic [N_LOCAL*N_TOTAL-1:0] adjacency,
  input  logic [N_LOCAL*WIDTH-1:0]   weights,
  input  logic                       start,
  output logic                       req_valid,
  input  logic                       req_ready,
  output logic [PW-1:0]              req_page,
  input  logic                       rsp_valid,
  input  logic [PW-1:0]              rsp_page,
  input  logic [WIDTH-1:0]           rsp_data,
  input  logic                       qry_valid,
  input  logic [PW-1:0]              qry_page,
  output logic                       rpl_valid,
  output logic [WIDTH-1:0]           rpl_data,
  output logic                       busy,
  output logic                       done,
  output logic [IW-1:0]              iter_count,
  output logic [N_LOCAL*WIDTH-1:0]   vals
);

  localparam int LW = $clog2(N_LOCAL);

  localparam logic [WIDTH-1:0] DB       = WIDTH'(pr_db(WIDTH));
  localparam logic [WIDTH-1:0] DN       = WIDTH'(pr_dn(WIDTH, N_TOTAL));
  localparam logic [WIDTH-1:0] INIT_V   = WIDTH'(pr_init_v(WIDTH, N_TOTAL));
  localparam logic [PW-1:0]    C_LAST   = PW'(N_TOTAL - 1);
  localparam logic [IW-1:0]    ITER_END = IW'(MAX_ITER);

  typedef logic [N_LOCAL-1:0][WIDTH-1:0]   vec_t;
  typedef logic [N_LOCAL-1:0][N_TOTAL-1:0] adj_t;

  pr_state_e         state_q, state_d;
  logic [PW-1:0]     c_q, c_d;
  logic [WIDTH-1:0]  contrib_q, contrib_d;
  vec_t              cur_q, cur_d, next_q, next_d;
  logic [IW-1:0]     iter_q, iter_d;
  logic              req_valid_q, req_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rpl_valid_q, rpl_valid_d;
  logic [WIDTH-1:0]  rpl_data_q, rpl_data_d;

  adj_t              adj_arr;
  vec_t              w_arr;
  vec_t              acc_sat;
  logic [N_LOCAL-1:0] col_bits;
  logic              c_local, c_last, iter_last, converged;
  logic [LW-1:0]     c_idx, q_idx;
  logic              q_local;
  logic [WIDTH-1:0]  loc_contrib, qry_contrib;

  assign adj_arr   = adjacency;
  assign w_arr     = weights;
  assign c_local   = (c_q[PW-1:LW] == tile_id);
  assign c_idx     = c_q[LW-1:0];
  assign c_last    = (c_q == C_LAST);
  assign iter_last = ((iter_q + 1'b1) == ITER_END);
  assign q_local   = (qry_page[PW-1:LW] == tile_id);
  assign q_idx     = qry_page[LW-1:0];

  // Per-row column tap and saturating accumulate of the staged contribution.
  for (genvar r = 0; r < N_LOCAL; r++) begin : g_row
    logic [WIDTH:0] sum;
    assign col_bits[r] = adj_arr[r][c_q];
    assign sum         = {1'b0, next_q[r]} + {1'b0, contrib_q};
    assign acc_sat[r]  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

`ifdef PR_CONVERGE_EN
  vec_t             diff;
  logic [WIDTH-1:0] delta;

  for (genvar r = 0; r < N_LOCAL; r++) begin : g_diff
    assign diff[r] = (next_q[r] >= cur_q[r]) ? (next_q[r] - cur_q[r])
                                             : (cur_q[r] - next_q[r]);
  end

  always_comb begin
    delta = '0;
    for (int i = 0; i < N_LOCAL; i++)
      if (diff[i] > delta) delta = diff[i];
  end

  assign converged = (int'(delta) < EPS);
`else
  // Constant false: without tracking only the iteration limit ends a run.
  assign converged = (EPS < 0);
`endif

  // Accumulate path: contribution of the current local column's page.
  pr_contrib #(.WIDTH(WIDTH), .DB(DB)) u_acc_contrib (
    .w (w_arr[c_idx]),
    .v (cur_q[c_idx]),
    .c (loc_contrib)
  );

  // Query path: always from committed values, independent of the FSM.
  pr_contrib #(.WIDTH(WIDTH), .DB(DB)) u_qry_contrib (
    .w (w_arr[q_idx]),
    .v (cur_q[q_idx]),
    .c (qry_contrib)
  );

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    contrib_d   = contrib_q;
    cur_d       = cur_q;
    next_d      = next_q;
    iter_d      = iter_q;
    req_valid_d = req_valid_q;
    busy_d      = busy_q;
    done_d      = done_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          iter_d  = '0;
        end
      end
      INIT: begin
        next_d  = {N_LOCAL{DN}};
        c_d     = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (col_bits == '0) begin
          if (c_last) state_d = COMMIT;
          else        c_d     = c_q + 1'b1;
        end else if (c_local) begin
          contrib_d = loc_contrib;
          state_d   = ACC;
        end else begin
          req_valid_d = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        // req_page is c_q, which only moves in SCAN/ACC, so it stays put here.
        if (req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (rsp_valid && (rsp_page == c_q)) begin
          contrib_d = rsp_data;
          state_d   = ACC;
        end
      end
      ACC: begin
        for (int i = 0; i < N_LOCAL; i++)
          if (col_bits[i]) next_d[i] = acc_sat[i];
        if (c_last) begin
          state_d = COMMIT;
        end else begin
          c_d     = c_q + 1'b1;
          state_d = SCAN;
        end
      end
      COMMIT: begin
        cur_d  = next_q;
        iter_d = iter_q + 1'b1;
        if (iter_last || converged) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = INIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rpl_valid_d = qry_valid && q_local;
    rpl_data_d  = (qry_valid && q_local) ? qry_contrib : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      c_q         <= '0;
      contrib_q   <= '0;
      cur_q       <= {N_LOCAL{INIT_V}};
      next_q      <= '0;
      iter_q      <= '0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rpl_valid_q <= 1'b0;
      rpl_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      contrib_q   <= contrib_d;
      cur_q       <= cur_d;
      next_q      <= next_d;
      iter_q      <= iter_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rpl_valid_q <= rpl_valid_d;
      rpl_data_q  <= rpl_data_d;
    end
  end

  assign req_valid  = req_valid_q;
  assign req_page   = c_q;
  assign rpl_valid  = rpl_valid_q;
  assign rpl_data   = rpl_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign iter_count = iter_q;
  assign vals       = cur_q;

endmodule

// File: doc/pagerank_tile.md
# pagerank_tile

- Iterative fixed-point PageRank engine for one tile of a multi-tile NoC system.
- Owns `N_LOCAL` pages out of `N_TOTAL` global pages.
- Each iteration: walks every global column once, sums the contributions of the incoming links into double-buffered page values, then commits.
- Serves contribution queries from other tiles over the NoC and fetches remote contributions through a request/response handshake.
- Iterates until converged or until `MAX_ITER` iterations have run.

## Interface
- `N_LOCAL`, 16: pages owned by this tile.
- `N_TOTAL`, 64: global page count; must be a power of two and a multiple of `N_LOCAL`.
- `WIDTH`, 16: fixed-point value width; unsigned, scaled by 2^WIDTH.
- `MAX_ITER`, 32: iteration limit.
- `EPS`, 4: convergence threshold, in LSBs.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `tile_id` in log2(N_TOTAL/N_LOCAL): this tile owns global pages `tile_id*N_LOCAL` to `tile_id*N_LOCAL+N_LOCAL-1`.
- `adjacency` in N_LOCAL*N_TOTAL: bit `[r*N_TOTAL+c]` = global page c links to local row r.
- `weights` in N_LOCAL*WIDTH: out-link weight (1/outdegree) of each local page.
- `start` in 1: single-cycle pulse that begins a run.
- `req_valid` out 1, `req_ready` in 1, `req_page` out log2(N_TOTAL): remote contribution request.
- `rsp_valid` in 1, `rsp_page` in log2(N_TOTAL), `rsp_data` in WIDTH: remote contribution response.
- `qry_valid` in 1, `qry_page` in log2(N_TOTAL): query from the NoC.
- `rpl_valid` out 1, `rpl_data` out WIDTH: reply to a query.
- `busy` out 1, `done` out 1: status. `done` is a sticky flag.
- `iter_count` out log2(MAX_ITER)+1: number of completed iterations.
- `vals` out N_LOCAL*WIDTH: committed page values.

## Operation
**Constants**
- `D_FIX` = round(0.15*2^WIDTH).
- `DB` = 2^WIDTH - `D_FIX`.
- `DN` = `D_FIX`/N_TOTAL.
- `INIT_V` = 2^WIDTH/N_TOTAL.

**Contribution**
- contrib(w,v) = (DB*w*v) >> (2*WIDTH), truncated to WIDTH bits.

**States**
- IDLE → INIT on `start`. `start` is ignored in any other state.
- INIT (1 cycle): every next[r] = `DN`; column index c = 0.
- SCAN (per column c):
  - If column c has no set bits, skip c.
  - If c is local, compute contrib of the local page internally and go to ACC.
  - If c is remote, go to REQ.
- REQ:
  - Drive `req_valid=1`, `req_page=c`.
  - `req_page` is held stable until `req_ready` is sampled high; then go to WAIT.
- WAIT:
  - Accept the first `rsp_valid` with `rsp_page==c`; go to ACC.
  - A response with any other page is dropped.
- ACC (1 cycle):
  - next[r] += contrib for every r with adj[r][c] set, all rows in parallel.
  - Addition saturates at 2^WIDTH-1.
  - If c == N_TOTAL-1 go to COMMIT, otherwise c+1 and go to SCAN.
- COMMIT (1 cycle):
  - cur = next; `iter_count` += 1.
  - delta = max over r of |next[r]-cur_old[r]|.
  - Go to DONE if the termination rule below holds, otherwise to INIT.
- DONE: assert `done`, then return to IDLE. `done` is cleared by the next `start`.

**Queries**
- Served in every state, always from committed cur values.
- If `qry_page` is local: `rpl_valid` and `rpl_data` = contrib(weight, cur) of that page.
- Non-local queries are ignored (`rpl_valid` stays 0).

## Timing
**Reset values**
- `req_valid` = 0, `rpl_valid` = 0, `busy` = 0, `done` = 0, `iter_count` = 0.
- All cur values = `INIT_V`.
- Reset mid-run aborts the run and returns the block to these values.

**Latency**
- Query reply: registered, exactly 1 cycle after `qry_valid`.
- SCAN of an empty or local column: 1 cycle, plus the ACC cycle.
- Remote column: REQ → WAIT → ACC; unbounded while the NoC stalls.

**Outputs**
- `busy` = 1 in INIT through COMMIT.
- A query sampled in the COMMIT cycle is answered with pre-commit values.

**Arithmetic**
- Multiply products are 3*WIDTH bits wide.
- No overflow check on `tile_id`; callers guarantee it is in range.

## Configuration
- `PR_CONVERGE_EN` defined:
  - Terminate when delta < `EPS` or `iter_count` == `MAX_ITER`.
  - delta is computed in COMMIT.
- `PR_CONVERGE_EN` undefined:
  - Terminate only when `iter_count` == `MAX_ITER`.
  - No delta logic is synthesized.

## Structure
**Package `pagerank_pkg`**
- Constants: `D_FIX`, `DB`, `DN`, `INIT_V` (computed from WIDTH and N_TOTAL).
- State enum: IDLE, INIT, SCAN, REQ, WAIT, ACC, COMMIT, DONE.

**Sub-module `pr_contrib`**
- Combinational contrib(w,v).
- Two instances: one on the accumulate path, one on the query-reply path.

## Test plan
Common configuration: N_LOCAL=4, N_TOTAL=8, WIDTH=16, `tile_id`=0 (owns pages 0-3). `DB`=0xD99A, `DN`=0x4CC, `INIT_V`=0x2000.

- **Reset state:** reset → all `vals`=0x2000, `iter_count`=0; `req_valid`, `rpl_valid`, `busy` and `done` all 0.
- **Query reply:** weight[1]=0x8000, `qry_page`=1 → next cycle `rpl_valid`=1, `rpl_data`=0x0D99. `qry_page`=6 → `rpl_valid`=0.
- **Zero adjacency, convergence enabled:** `PR_CONVERGE_EN` defined, `start` → after iteration 1 all `vals`=0x04CC; `done` asserted with `iter_count`=2; `req_valid` never asserted.
- **Remote fetch handshake:** only adj[0][5] set, `req_ready` held low for 3 cycles → `req_page`=5 stays stable. Then a response with `rsp_page`=4 is dropped, and a response with `rsp_page`=5, `rsp_data`=0x0100 gives vals[0]=0x05CC after commit.
- **Saturation:** all local columns linked to row 0, weights=0xFFFF, values near max → vals[0] clamps at 0xFFFF, no wrap.
- **Reset and start edge cases:**
  - Reset during WAIT → outputs return to their reset values immediately.
  - `start` while `busy` → ignored.
  - Convergence disabled → run ends at `iter_count`=`MAX_ITER`.
